// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serialiser paced by a 16x oversampling baud tick
//
// Purpose:
//   Sends one frame per accepted request: start bit (0), D_BIT data bits LSB
//   first, an optional even-parity bit, then a stop period of SB_TICK ticks (1).
//   Every bit lasts 16 s_tick pulses; the line output is registered.
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, inserts an even-parity bit after the
//   data bits. Left undefined, no parity state or logic exists.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   s_tick       baud oversample tick, one clk wide, 16 per bit period
//   tx_start     send request, only looked at while idle
//   din          word to send, captured on the accepted tx_start cycle
//   tx           serial line, idles high
//   busy         high while a frame is in progress
//   tx_done_tick one-clk pulse on the tick that ends the stop period

module uart_tx #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] din,
  output logic             tx,
  output logic             busy,
  output logic             tx_done_tick
);

  // Tick counter must reach both 15 and SB_TICK-1 (up to 31 for 2 stop bits).
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = ($clog2(D_BIT) > 1) ? $clog2(D_BIT) : 1;

  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(D_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_cnt_q, s_cnt_d;
  logic [NW-1:0]    n_cnt_q, n_cnt_d;
  logic [D_BIT-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_cnt_d      = n_cnt_q;
    shreg_d      = shreg_q;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A tick arriving with the request is not counted toward the start bit.
        if (tx_start) begin
          shreg_d = din;
          s_cnt_d = '0;
          n_cnt_d = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^din;
`endif
        end
      end

      S_START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = S_DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      S_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shreg_d = shreg_q >> 1;
            if (n_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            state_d = S_STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif

      S_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            // Gated by rst so an aborting reset never reports completion.
            tx_done_tick = rst;
            s_cnt_d      = '0;
            state_d      = S_IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the upcoming state so tx changes on the same edge as
  // the state, one clk after acceptance for the start bit.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      s_cnt_q  <= '0;
      n_cnt_q  <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_cnt_q  <= s_cnt_d;
      n_cnt_q  <= n_cnt_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model

module tb_uart_tx;

  localparam int D  = 8;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int TOTAL = 16 * (1 + D + P) + SB;  // ticks per frame
  localparam int FCLK  = 4 * TOTAL;              // clks per frame at 1 tick / 4 clks
  localparam int HMAX  = 65536;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_tick = 1'b0;
  logic         tx_start = 1'b0;
  logic [D-1:0] din = '0;
  logic         tx, busy, tx_done_tick;

  uart_tx #(.D_BIT(D), .SB_TICK(SB)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  logic chk_en = 1'b0;
  logic hist_tx   [0:HMAX-1];
  logic hist_busy [0:HMAX-1];
  logic hist_done [0:HMAX-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at sample %0d: got %0h expected %0h", name, ncyc, act, exp);
    end
  endtask

  // Frame-level model: a frame is a bit list, each bit held 16 counted ticks.
  logic         m_active = 1'b0;
  int           m_n = 0;
  logic [D-1:0] m_word = '0;

  function automatic logic frame_bit(input logic [D-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= D) return w[idx-1];
    if (P == 1 && idx == D + 1) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
    end else if (m_active) begin
      if (s_tick) begin
        if (m_n == TOTAL - 1) begin
          m_active <= 1'b0;
          m_n      <= 0;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end else if (tx_start) begin
      m_active <= 1'b1;
      m_n      <= 0;
      m_word   <= din;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, m_active ? frame_bit(m_word, m_n / 16) : 1'b1);
      check("busy", busy, m_active);
      check("done", tx_done_tick, rst && m_active && s_tick && (m_n == TOTAL - 1));
    end
    if (ncyc < HMAX) begin
      hist_tx[ncyc]   <= tx;
      hist_busy[ncyc] <= busy;
      hist_done[ncyc] <= tx_done_tick;
    end
    ncyc <= ncyc + 1;
  end

  int   tick_ctr = 0;
  logic rand_tick = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_ctr++;
    if (rand_tick) s_tick = ($urandom_range(0, 3) == 0);
    else           s_tick = (tick_ctr % 4 == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Accept in a cycle that also carries a tick, so bit edges fall exactly
  // every 64 clks from the first low sample t0.
  task automatic start_aligned(input logic [D-1:0] w, output int t0);
    int g = 0;
    while (!(s_tick === 1'b1 && busy === 1'b0) && g < 4000) begin
      cyc();
      g++;
    end
    if (g >= 4000) check("start_wait_timeout", 0, 1);
    tx_start = 1'b1;
    din      = w;
    t0       = ncyc + 1;
    cyc();
    tx_start = 1'b0;
  endtask

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi && i < HMAX; i++) if (hist_done[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_low(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi && i < HMAX; i++) if (hist_tx[i] !== 1'b1) c++;
    return c;
  endfunction

  int   t0, t1, lo, s, g;
  logic exp_a5 [0:10];

  initial begin
    // Reset with tx_start held high: nothing may start.
    rst = 1'b0;
    tx_start = 1'b1;
    din = 8'hAA;
    run(3);
    #2;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done_tick, 1'b0);
    chk_en = 1'b1;
    rst = 1'b1;
    tx_start = 1'b0;
    run(8);
    check("post_rst_busy", busy, 1'b0);

    // Single frame 8'hA5.
    if (P == 1) exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    else        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    start_aligned(8'hA5, t0);
    run(FCLK + 60);
    for (int i = 0; i < 2 + D + P; i++)
      check($sformatf("a5_bit%0d", i), hist_tx[t0 + 32 + 64 * i], exp_a5[i]);
    check("a5_done_pos", hist_done[t0 + (P == 1 ? 703 : 639)], 1'b1);
    check("a5_done_cnt", count_done(t0, t0 + FCLK + 50), 1);

    // Request while busy with 8'hFF is dropped.
    start_aligned(8'hFF, t0);
    run(300);
    tx_start = 1'b1;
    din = 8'h3C;
    cyc();
    tx_start = 1'b0;
    run(2 * FCLK);
    check("ff_data_zeros", count_low(t0 + 64, t0 + 64 * (1 + D)), 0);
    check("ff_no_second", count_low(t0 + FCLK, ncyc - 1), 0);
    check("ff_done_cnt", count_done(t0, ncyc - 1), 1);

    // Back-to-back with tx_start held: 8'h00 then 8'h81.
    lo = ncyc;
    tx_start = 1'b1;
    din = 8'h00;
    g = 0;
    while (busy !== 1'b1 && g < 20) begin cyc(); g++; end
    din = 8'h81;
    g = 0;
    while (busy === 1'b1 && g < 2 * FCLK) begin cyc(); g++; end
    cyc();
    check("b2b_reaccept", busy, 1'b1);
    tx_start = 1'b0;
    run(FCLK + 50);
    s = -1;
    for (int i = lo; i < ncyc - 1; i++) if (s < 0 && hist_done[i] === 1'b1) s = i;
    if (s < 0) begin
      check("b2b_first_done_seen", 0, 1);
    end else begin
      check("b2b_gap_tx", hist_tx[s + 1], 1'b1);
      check("b2b_gap_busy", hist_busy[s + 1], 1'b0);
      check("b2b_second_start", hist_tx[s + 2], 1'b0);
      check("b2b_81_bit0", hist_tx[s + 2 + 64 + 32], 1'b1);
      check("b2b_81_bit1", hist_tx[s + 2 + 128 + 32], 1'b0);
    end
    check("b2b_done_cnt", count_done(lo, ncyc - 1), 2);

    // Reset during data bit 3 of 8'h55.
    start_aligned(8'h55, t0);
    while (ncyc < t0 + 280) cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    run(FCLK);
    check("abort_in_bit3", hist_tx[t0 + 280], 1'b0);
    check("abort_tx", hist_tx[t0 + 281], 1'b1);
    check("abort_busy", hist_busy[t0 + 281], 1'b0);
    check("abort_no_done", count_done(t0, ncyc - 1), 0);
    start_aligned(D'($urandom), t1);
    run(FCLK + 50);
    check("after_abort_done", count_done(t1, ncyc - 1), 1);

`ifdef UART_TX_PARITY_EN
    start_aligned(8'h07, t0);
    run(FCLK + 50);
    check("par07", hist_tx[t0 + 32 + 64 * 9], 1'b1);
    check("par07_done_pos", hist_done[t0 + 703], 1'b1);
    start_aligned(8'h03, t0);
    run(FCLK + 50);
    check("par03", hist_tx[t0 + 32 + 64 * 9], 1'b0);
`endif

    // Random ticks, requests, data churn and occasional resets.
    rand_tick = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      tx_start = ($urandom_range(0, 39) == 0);
      din      = D'($urandom);
      rst      = !($urandom_range(0, 2999) == 0);
      cyc();
    end
    rst = 1'b1;
    tx_start = 1'b0;
    run(3000);
    check("drain_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
